// File: rtl/routing_table_prog.sv
// Programmable per-node routing table for a MESH_X x MESH_Y NoC router.
// Optional write-lock is enabled by defining ROUTE_TABLE_LOCK_EN.
module routing_table_prog #(
  parameter int NODE_ID    = 0,
  parameter int MESH_X     = 4,
  parameter int MESH_Y     = 4,
  parameter int ADDR_SZ    = 4,
  parameter int BITS_DIR   = 3,
  parameter int ROUTE_MODE = 0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                init_done,
  input  logic                lookup_req,
  input  logic [ADDR_SZ-1:0]  lookup_addr,
  output logic                lookup_valid,
  output logic [BITS_DIR-1:0] lookup_dir,
  output logic                lookup_err,
`ifdef ROUTE_TABLE_LOCK_EN
  input  logic                cfg_lock,
`endif
  input  logic                cfg_we,
  input  logic [ADDR_SZ-1:0]  cfg_addr,
  input  logic [BITS_DIR-1:0] cfg_data,
  output logic                cfg_err
);

  localparam int NUM_NODES = MESH_X * MESH_Y;
  localparam int IDX_W     = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int MY_X      = NODE_ID % MESH_X;
  localparam int MY_Y      = NODE_ID / MESH_X;

  localparam logic [BITS_DIR-1:0] DIR_N     = BITS_DIR'(0);
  localparam logic [BITS_DIR-1:0] DIR_E     = BITS_DIR'(1);
  localparam logic [BITS_DIR-1:0] DIR_S     = BITS_DIR'(2);
  localparam logic [BITS_DIR-1:0] DIR_W     = BITS_DIR'(3);
  localparam logic [BITS_DIR-1:0] DIR_LOCAL = BITS_DIR'(4);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [BITS_DIR-1:0] table_q [NUM_NODES];

  logic                lookup_valid_q, lookup_valid_d;
  logic                lookup_err_q, lookup_err_d;
  logic [BITS_DIR-1:0] lookup_dir_q, lookup_dir_d;
  logic                cfg_err_q, cfg_err_d;

  logic run;
  logic lookup_in_range;
  logic cfg_addr_ok;
  logic cfg_data_ok;
  logic cfg_locked;
  logic wr_en;

  function automatic logic [BITS_DIR-1:0] default_dir(input int d);
    int dx;
    int dy;
    logic [BITS_DIR-1:0] x_dir;
    logic [BITS_DIR-1:0] y_dir;
    dx = d % MESH_X;
    dy = d / MESH_X;
    x_dir = (dx > MY_X) ? DIR_E : (dx < MY_X) ? DIR_W : DIR_LOCAL;
    y_dir = (dy > MY_Y) ? DIR_S : (dy < MY_Y) ? DIR_N : DIR_LOCAL;
    if (ROUTE_MODE == 0) default_dir = (x_dir != DIR_LOCAL) ? x_dir : y_dir;
    else                 default_dir = (y_dir != DIR_LOCAL) ? y_dir : x_dir;
  endfunction

  assign run             = (state_q == S_RUN);
  assign init_done       = run;
  assign lookup_in_range = (32'(lookup_addr) < NUM_NODES);
  assign cfg_addr_ok     = (32'(cfg_addr) < NUM_NODES);
  assign cfg_data_ok     = (32'(cfg_data) <= 4);

`ifdef ROUTE_TABLE_LOCK_EN
  // Sticky: once set in RUN, only reset clears it. The setting cycle's write still lands.
  logic lock_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_q <= 1'b0;
    else       lock_q <= lock_q | (run & cfg_lock);
  end
  assign cfg_locked = lock_q;
`else
  assign cfg_locked = 1'b0;
`endif

  assign wr_en = cfg_we & run & cfg_addr_ok & cfg_data_ok & ~cfg_locked;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (32'(cnt_q) == NUM_NODES - 1) state_d = S_RUN;
    end
  end

  // Init fill and runtime writes share one port; they never overlap because
  // runtime writes are only accepted in RUN.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT)
      table_q[cnt_q] <= default_dir(32'(cnt_q));
    else if (wr_en)
      table_q[cfg_addr[IDX_W-1:0]] <= cfg_data;
  end

  // Lookup handshake: lookup_req is accepted on any RUN edge (no back-pressure);
  // lookup_valid is high for exactly the cycle after each accepted request, and
  // lookup_dir/lookup_err are only meaningful while it is high. The read uses the
  // pre-edge table, so a same-cycle write is not visible to it.
  always_comb begin
    lookup_valid_d = run & lookup_req;
    lookup_err_d   = run & lookup_req & ~lookup_in_range;
    lookup_dir_d   = '0;
    if (run && lookup_req && lookup_in_range)
      lookup_dir_d = table_q[lookup_addr[IDX_W-1:0]];
    cfg_err_d = cfg_we & (~run | ~cfg_addr_ok | ~cfg_data_ok | cfg_locked);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lookup_valid_q <= 1'b0;
      lookup_err_q   <= 1'b0;
      lookup_dir_q   <= '0;
      cfg_err_q      <= 1'b0;
    end else begin
      lookup_valid_q <= lookup_valid_d;
      lookup_err_q   <= lookup_err_d;
      lookup_dir_q   <= lookup_dir_d;
      cfg_err_q      <= cfg_err_d;
    end
  end

  assign lookup_valid = lookup_valid_q;
  assign lookup_err   = lookup_err_q;
  assign lookup_dir   = lookup_dir_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_routing_table_prog.sv
// Directed bench for routing_table_prog: four instances (4x4 XY node 5, 4x4 YX node 5,
// 4x4 XY node 0, 3x3 XY node 0) sharing clock and reset.
module tb_routing_table_prog;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // a: 4x4 XY node 5
  logic a_done, a_req, a_valid, a_err, a_we, a_cerr;
  logic [3:0] a_addr, a_caddr;
  logic [2:0] a_dir, a_cdata;
  // b: 4x4 YX node 5
  logic b_done, b_req, b_valid, b_err, b_we, b_cerr;
  logic [3:0] b_addr, b_caddr;
  logic [2:0] b_dir, b_cdata;
  // c: 4x4 XY node 0
  logic c_done, c_req, c_valid, c_err, c_we, c_cerr;
  logic [3:0] c_addr, c_caddr;
  logic [2:0] c_dir, c_cdata;
  // d: 3x3 XY node 0
  logic d_done, d_req, d_valid, d_err, d_we, d_cerr;
  logic [3:0] d_addr, d_caddr;
  logic [2:0] d_dir, d_cdata;
`ifdef ROUTE_TABLE_LOCK_EN
  logic a_lock = 1'b0, b_lock = 1'b0, c_lock = 1'b0, d_lock = 1'b0;
`endif

  routing_table_prog #(.NODE_ID(5), .MESH_X(4), .MESH_Y(4), .ADDR_SZ(4), .BITS_DIR(3), .ROUTE_MODE(0)) u_a (
    .clk(clk), .reset(reset), .init_done(a_done), .lookup_req(a_req), .lookup_addr(a_addr),
    .lookup_valid(a_valid), .lookup_dir(a_dir), .lookup_err(a_err),
`ifdef ROUTE_TABLE_LOCK_EN
    .cfg_lock(a_lock),
`endif
    .cfg_we(a_we), .cfg_addr(a_caddr), .cfg_data(a_cdata), .cfg_err(a_cerr));

  routing_table_prog #(.NODE_ID(5), .MESH_X(4), .MESH_Y(4), .ADDR_SZ(4), .BITS_DIR(3), .ROUTE_MODE(1)) u_b (
    .clk(clk), .reset(reset), .init_done(b_done), .lookup_req(b_req), .lookup_addr(b_addr),
    .lookup_valid(b_valid), .lookup_dir(b_dir), .lookup_err(b_err),
`ifdef ROUTE_TABLE_LOCK_EN
    .cfg_lock(b_lock),
`endif
    .cfg_we(b_we), .cfg_addr(b_caddr), .cfg_data(b_cdata), .cfg_err(b_cerr));

  routing_table_prog #(.NODE_ID(0), .MESH_X(4), .MESH_Y(4), .ADDR_SZ(4), .BITS_DIR(3), .ROUTE_MODE(0)) u_c (
    .clk(clk), .reset(reset), .init_done(c_done), .lookup_req(c_req), .lookup_addr(c_addr),
    .lookup_valid(c_valid), .lookup_dir(c_dir), .lookup_err(c_err),
`ifdef ROUTE_TABLE_LOCK_EN
    .cfg_lock(c_lock),
`endif
    .cfg_we(c_we), .cfg_addr(c_caddr), .cfg_data(c_cdata), .cfg_err(c_cerr));

  routing_table_prog #(.NODE_ID(0), .MESH_X(3), .MESH_Y(3), .ADDR_SZ(4), .BITS_DIR(3), .ROUTE_MODE(0)) u_d (
    .clk(clk), .reset(reset), .init_done(d_done), .lookup_req(d_req), .lookup_addr(d_addr),
    .lookup_valid(d_valid), .lookup_dir(d_dir), .lookup_err(d_err),
`ifdef ROUTE_TABLE_LOCK_EN
    .cfg_lock(d_lock),
`endif
    .cfg_we(d_we), .cfg_addr(d_caddr), .cfg_data(d_cdata), .cfg_err(d_cerr));

  task automatic idle_all();
    a_req = 0; a_addr = 0; a_we = 0; a_caddr = 0; a_cdata = 0;
    b_req = 0; b_addr = 0; b_we = 0; b_caddr = 0; b_cdata = 0;
    c_req = 0; c_addr = 0; c_we = 0; c_caddr = 0; c_cdata = 0;
    d_req = 0; d_addr = 0; d_we = 0; d_caddr = 0; d_cdata = 0;
  endtask

  // Pulse reset, release it away from the edge, and count edges until c sees init_done.
  task automatic reset_and_init(output int n);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n = 0;
    while (!c_done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    int d_edge;
    idle_all();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_done, a_valid, a_err, a_cerr, a_dir} !== 7'b0 || {d_done, d_valid, d_err, d_cerr, d_dir} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs a=%b d=%b required all zero",
               {a_done, a_valid, a_err, a_cerr, a_dir}, {d_done, d_valid, d_err, d_cerr, d_dir});
    end
    reset = 1'b0;
    n = 0;
    d_edge = 0;
    while (!a_done && n < 40) begin
      // Edge 2: write to d and lookup on c while both are still in INIT.
      d_we = (n == 1); d_caddr = 4'd4; d_cdata = 3'd0;
      c_req = (n == 1); c_addr = 4'd0;
      @(posedge clk); #1;
      n++;
      if (n == 2) begin
        checks++;
        if (d_cerr !== 1'b1) begin
          errors++; $display("FAIL init_write_err got=%b required=1", d_cerr);
        end
        checks++;
        if (c_valid !== 1'b0 || c_err !== 1'b0) begin
          errors++; $display("FAIL init_lookup_dropped valid=%b err=%b required 0 0", c_valid, c_err);
        end
      end
      if (n == 3) begin
        checks++;
        if (d_cerr !== 1'b0) begin
          errors++; $display("FAIL init_write_err_pulse got=%b required=0", d_cerr);
        end
      end
      if (n == 15) begin
        checks++;
        if (a_done !== 1'b0) begin
          errors++; $display("FAIL init_done_early got=%b required=0 at edge 15", a_done);
        end
      end
      if (d_done && d_edge == 0) d_edge = n;
    end
    checks++;
    if (n != 16 || !b_done || !c_done) begin
      errors++; $display("FAIL init_done_4x4 edges=%0d required=16 b=%b c=%b", n, b_done, c_done);
    end
    checks++;
    if (d_edge != 9) begin
      errors++; $display("FAIL init_done_3x3 edges=%0d required=9", d_edge);
    end
    // Entry 4 of d must still hold its default (E) after the rejected INIT write.
    d_req = 1; d_addr = 4'd4;
    @(posedge clk); #1;
    d_req = 0;
    checks++;
    if (d_valid !== 1'b1 || d_dir !== 3'd1) begin
      errors++; $display("FAIL init_write_ignored valid=%b dir=%0d required 1 1", d_valid, d_dir);
    end
  endtask

  task automatic test_lookup_xy();
    logic [3:0] addrs [5];
    logic [2:0] exps [5];
    addrs = '{4'd0, 4'd5, 4'd7, 4'd9, 4'd13};
    exps  = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd2};
    for (int i = 0; i < 5; i++) begin
      a_req = 1; a_addr = addrs[i];
      @(posedge clk); #1;
      checks++;
      if (a_valid !== 1'b1 || a_err !== 1'b0 || a_dir !== exps[i]) begin
        errors++;
        $display("FAIL xy_lookup addr=%0d valid=%b err=%b dir=%0d required 1 0 %0d",
                 addrs[i], a_valid, a_err, a_dir, exps[i]);
      end
    end
    a_req = 0;
    @(posedge clk); #1;
    checks++;
    if (a_valid !== 1'b0) begin
      errors++; $display("FAIL xy_valid_drop got=%b required=0", a_valid);
    end
  endtask

  task automatic test_lookup_yx();
    logic [3:0] addrs [4];
    logic [2:0] exps [4];
    addrs = '{4'd0, 4'd3, 4'd9, 4'd5};
    exps  = '{3'd0, 3'd0, 3'd2, 3'd4};
    for (int i = 0; i < 4; i++) begin
      b_req = 1; b_addr = addrs[i];
      @(posedge clk); #1;
      checks++;
      if (b_valid !== 1'b1 || b_err !== 1'b0 || b_dir !== exps[i]) begin
        errors++;
        $display("FAIL yx_lookup addr=%0d valid=%b err=%b dir=%0d required 1 0 %0d",
                 addrs[i], b_valid, b_err, b_dir, exps[i]);
      end
    end
    b_req = 0;
  endtask

  task automatic test_read_before_write();
    c_we = 1; c_caddr = 4'd6; c_cdata = 3'd2;
    c_req = 1; c_addr = 4'd6;
    @(posedge clk); #1;
    c_we = 0;
    checks++;
    if (c_valid !== 1'b1 || c_dir !== 3'd1 || c_cerr !== 1'b0) begin
      errors++; $display("FAIL rbw_old valid=%b dir=%0d cfg_err=%b required 1 1 0", c_valid, c_dir, c_cerr);
    end
    @(posedge clk); #1;
    c_req = 0;
    checks++;
    if (c_valid !== 1'b1 || c_dir !== 3'd2 || c_cerr !== 1'b0) begin
      errors++; $display("FAIL rbw_new valid=%b dir=%0d cfg_err=%b required 1 2 0", c_valid, c_dir, c_cerr);
    end
  endtask

  task automatic test_errors();
    d_req = 1; d_addr = 4'd12;
    @(posedge clk); #1;
    d_req = 0;
    checks++;
    if (d_valid !== 1'b1 || d_err !== 1'b1 || d_dir !== 3'd0) begin
      errors++; $display("FAIL oor_lookup valid=%b err=%b dir=%0d required 1 1 0", d_valid, d_err, d_dir);
    end
    d_we = 1; d_caddr = 4'd9; d_cdata = 3'd1;
    @(posedge clk); #1;
    checks++;
    if (d_cerr !== 1'b1) begin
      errors++; $display("FAIL oor_write_err got=%b required=1", d_cerr);
    end
    d_caddr = 4'd1; d_cdata = 3'd6;
    @(posedge clk); #1;
    d_we = 0;
    checks++;
    if (d_cerr !== 1'b1) begin
      errors++; $display("FAIL bad_data_err got=%b required=1", d_cerr);
    end
    d_req = 1; d_addr = 4'd1;
    @(posedge clk); #1;
    d_req = 0;
    checks++;
    if (d_cerr !== 1'b0 || d_dir !== 3'd1 || d_err !== 1'b0) begin
      errors++; $display("FAIL bad_data_unchanged cfg_err=%b dir=%0d err=%b required 0 1 0", d_cerr, d_dir, d_err);
    end
    // Entry 0 (local) must not be touched by the rejected write to address 9.
    d_req = 1; d_addr = 4'd0;
    @(posedge clk); #1;
    d_req = 0;
    checks++;
    if (d_dir !== 3'd4) begin
      errors++; $display("FAIL no_alias dir=%0d required=4", d_dir);
    end
  endtask

  task automatic test_reset_restart();
    int n;
    c_we = 1; c_caddr = 4'd3; c_cdata = 3'd0;
    @(posedge clk); #1;
    c_we = 0;
    c_req = 1; c_addr = 4'd3;
    @(posedge clk); #1;
    c_req = 0;
    checks++;
    if (c_dir !== 3'd0) begin
      errors++; $display("FAIL restart_prewrite dir=%0d required=0", c_dir);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    checks++;
    if (c_done !== 1'b0) begin
      errors++; $display("FAIL restart_mid_init done=%b required=0", c_done);
    end
    reset = 1'b1;
    #3;
    checks++;
    if (c_done !== 1'b0 || c_valid !== 1'b0) begin
      errors++; $display("FAIL restart_async done=%b valid=%b required 0 0", c_done, c_valid);
    end
    reset_and_init(n);
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL restart_init_edges got=%0d required=16", n);
    end
    c_req = 1; c_addr = 4'd3;
    @(posedge clk); #1;
    c_req = 0;
    checks++;
    if (c_valid !== 1'b1 || c_dir !== 3'd1) begin
      errors++; $display("FAIL restart_default valid=%b dir=%0d required 1 1", c_valid, c_dir);
    end
  endtask

`ifdef ROUTE_TABLE_LOCK_EN
  task automatic test_lock();
    int n;
    c_lock = 1; c_we = 1; c_caddr = 4'd2; c_cdata = 3'd3;
    @(posedge clk); #1;
    c_lock = 0;
    checks++;
    if (c_cerr !== 1'b0) begin
      errors++; $display("FAIL lock_same_cycle cfg_err=%b required=0", c_cerr);
    end
    c_cdata = 3'd0;
    @(posedge clk); #1;
    c_we = 0;
    checks++;
    if (c_cerr !== 1'b1) begin
      errors++; $display("FAIL lock_reject cfg_err=%b required=1", c_cerr);
    end
    c_req = 1; c_addr = 4'd2;
    @(posedge clk); #1;
    c_req = 0;
    checks++;
    if (c_valid !== 1'b1 || c_dir !== 3'd3) begin
      errors++; $display("FAIL lock_value valid=%b dir=%0d required 1 3", c_valid, c_dir);
    end
    reset_and_init(n);
    c_we = 1; c_caddr = 4'd2; c_cdata = 3'd0;
    @(posedge clk); #1;
    c_we = 0;
    checks++;
    if (c_cerr !== 1'b0) begin
      errors++; $display("FAIL lock_cleared cfg_err=%b required=0", c_cerr);
    end
    c_req = 1; c_addr = 4'd2;
    @(posedge clk); #1;
    c_req = 0;
    checks++;
    if (c_dir !== 3'd0) begin
      errors++; $display("FAIL lock_cleared_value dir=%0d required=0", c_dir);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lookup_xy();
    test_lookup_yx();
    test_read_before_write();
    test_errors();
    test_reset_restart();
`ifdef ROUTE_TABLE_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
